// File: rtl/trace_recorder.sv
// trace_recorder: commit-trace capture into a circular buffer with PC trigger and post-trigger window.
// Latency: capture write and counter updates on the edge sampling cap_valid; readout 1 entry/cycle.
// Backpressure: rd_* held stable while rd_valid && !rd_ready. Build option: define TRACE_WB_EN to store writeback fields.
module trace_recorder #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_valid,
  input  logic [DATA_W-1:0]        cap_pc,
  input  logic [DATA_W-1:0]        cap_instr,
  input  logic                     cap_wb_en,
  input  logic [4:0]               cap_wb_addr,
  input  logic [DATA_W-1:0]        cap_wb_data,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     rd_start,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_wb_data,
  output logic                     rd_wb_en,
  output logic [4:0]               rd_wb_addr,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef TRACE_WB_EN
  localparam int ENTRY_W = 3*DATA_W + 6;
`else
  localparam int ENTRY_W = 2*DATA_W;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE,
    S_READ
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   post_cnt_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic               rd_valid_q;
  logic               busy_q;
  logic               done_q;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               wr_en;
  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] rd_entry;
  logic [CNT_W-1:0]   count_d;
  logic [PTR_W-1:0]   oldest;
  logic               full;

  assign full    = (count_q == CNT_W'(DEPTH));
  // Saturating entry count: once full, each new write overwrites the oldest entry.
  assign count_d = full ? count_q : count_q + CNT_W'(1);
  assign oldest  = full ? wr_ptr_q : '0;
  assign wr_en   = cap_valid && ((state_q == S_ARMED) || (state_q == S_POST));

`ifdef TRACE_WB_EN
  assign entry_d = {cap_wb_en, cap_wb_addr, cap_wb_data, cap_instr, cap_pc};
`else
  assign entry_d = {cap_instr, cap_pc};
  wire unused_wb = ^{cap_wb_en, cap_wb_addr, cap_wb_data};
`endif

  // Buffer storage: written only while recording, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  // Control FSM: capture pointers, trigger window, readout pointers and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (cap_valid) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            count_q  <= count_d;
            if (cap_pc == trig_pc) begin
              if (POST_TRIG == 0) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                post_cnt_q <= PTR_W'(POST_TRIG);
                state_q    <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (cap_valid) begin
            wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            post_cnt_q <= post_cnt_q - PTR_W'(1);
            if (post_cnt_q == PTR_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A re-arm takes precedence over a simultaneous readout request.
          if (arm) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            state_q  <= S_ARMED;
          end else if (rd_start) begin
            done_q <= 1'b0;
            if (count_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              rd_ptr_q   <= oldest;
              rd_cnt_q   <= count_q;
              rd_valid_q <= 1'b1;
              state_q    <= S_READ;
            end
          end
        end
        S_READ: begin
          if (rd_ready) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            rd_cnt_q <= rd_cnt_q - CNT_W'(1);
            if (rd_cnt_q == CNT_W'(1)) begin
              rd_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          rd_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Readout fields come straight from the buffer and are forced to zero outside READ.
  always_comb begin
    rd_entry   = rd_valid_q ? mem_q[rd_ptr_q] : '0;
    rd_pc      = rd_entry[DATA_W-1:0];
    rd_instr   = rd_entry[2*DATA_W-1:DATA_W];
`ifdef TRACE_WB_EN
    rd_wb_data = rd_entry[3*DATA_W-1:2*DATA_W];
    rd_wb_addr = rd_entry[3*DATA_W+4:3*DATA_W];
    rd_wb_en   = rd_entry[3*DATA_W+5];
`else
    rd_wb_data = '0;
    rd_wb_addr = '0;
    rd_wb_en   = 1'b0;
`endif
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_valid_q && (rd_cnt_q == CNT_W'(1));
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_trace_recorder.sv
module tb_trace_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cap_valid, cap_wb_en, arm, rd_start, rd_ready;
  logic [31:0] cap_pc, cap_instr, cap_wb_data, trig_pc;
  logic [4:0]  cap_wb_addr;

  // Two instances share stimulus: a small one with an immediate stop, a larger one with a post window.
  logic        rd_valid0, rd_wb_en0, rd_last0, busy0, done0;
  logic [31:0] rd_pc0, rd_instr0, rd_wb_data0;
  logic [4:0]  rd_wb_addr0;
  logic [2:0]  count0;
  logic        rd_valid1, rd_wb_en1, rd_last1, busy1, done1;
  logic [31:0] rd_pc1, rd_instr1, rd_wb_data1;
  logic [4:0]  rd_wb_addr1;
  logic [3:0]  count1;

  trace_recorder #(.DATA_W(32), .DEPTH(4), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_wb_en(cap_wb_en), .cap_wb_addr(cap_wb_addr), .cap_wb_data(cap_wb_data),
    .arm(arm), .trig_pc(trig_pc), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_instr(rd_instr0), .rd_wb_data(rd_wb_data0),
    .rd_wb_en(rd_wb_en0), .rd_wb_addr(rd_wb_addr0), .rd_last(rd_last0),
    .busy(busy0), .done(done0), .count(count0)
  );

  trace_recorder #(.DATA_W(32), .DEPTH(8), .POST_TRIG(3)) u_dut1 (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_wb_en(cap_wb_en), .cap_wb_addr(cap_wb_addr), .cap_wb_data(cap_wb_data),
    .arm(arm), .trig_pc(trig_pc), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_valid(rd_valid1), .rd_pc(rd_pc1), .rd_instr(rd_instr1), .rd_wb_data(rd_wb_data1),
    .rd_wb_en(rd_wb_en1), .rd_wb_addr(rd_wb_addr1), .rd_last(rd_last1),
    .busy(busy1), .done(done1), .count(count1)
  );

  logic        o_valid[2], o_last[2], o_busy[2], o_done[2], o_wbe[2];
  logic [31:0] o_pc[2], o_ins[2], o_wbd[2], o_cnt[2];
  logic [4:0]  o_wba[2];
  assign o_valid[0] = rd_valid0;   assign o_valid[1] = rd_valid1;
  assign o_last[0]  = rd_last0;    assign o_last[1]  = rd_last1;
  assign o_busy[0]  = busy0;       assign o_busy[1]  = busy1;
  assign o_done[0]  = done0;       assign o_done[1]  = done1;
  assign o_wbe[0]   = rd_wb_en0;   assign o_wbe[1]   = rd_wb_en1;
  assign o_pc[0]    = rd_pc0;      assign o_pc[1]    = rd_pc1;
  assign o_ins[0]   = rd_instr0;   assign o_ins[1]   = rd_instr1;
  assign o_wbd[0]   = rd_wb_data0; assign o_wbd[1]   = rd_wb_data1;
  assign o_wba[0]   = rd_wb_addr0; assign o_wba[1]   = rd_wb_addr1;
  assign o_cnt[0]   = 32'(count0); assign o_cnt[1]   = 32'(count1);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the list of commits issued since arm, plus the trigger index.
  logic [31:0] m_pc[20], m_ins[20], m_wbd[20];
  logic        m_wbe[20];
  logic [4:0]  m_wba[20];
  int          n_com, t_idx;
  int          dep[2], pst[2];
  int          q0[$], q1[$];

  // Recorded window = commits up to trigger+post (or all if the window never closes);
  // the buffer holds the newest min(len, depth) of those.
  task automatic model(input int k, output int first, output int last, output bit dn);
    int len, cnt;
    if (t_idx >= 0 && t_idx + pst[k] <= n_com - 1) begin
      last = t_idx + pst[k];
      dn   = 1'b1;
    end else begin
      last = n_com - 1;
      dn   = 1'b0;
    end
    len   = last + 1;
    cnt   = (len < dep[k]) ? len : dep[k];
    first = len - cnt;
  endtask

  task automatic check_entry(input int k, input int i, input bit is_last);
    check($sformatf("d%0d_valid", k), 64'(o_valid[k]), 64'(1));
    check($sformatf("d%0d_pc", k),    64'(o_pc[k]),    64'(m_pc[i]));
    check($sformatf("d%0d_instr", k), 64'(o_ins[k]),   64'(m_ins[i]));
    check($sformatf("d%0d_last", k),  64'(o_last[k]),  64'(is_last));
`ifdef TRACE_WB_EN
    check($sformatf("d%0d_wbe", k),   64'(o_wbe[k]),   64'(m_wbe[i]));
    check($sformatf("d%0d_wba", k),   64'(o_wba[k]),   64'(m_wba[i]));
    check($sformatf("d%0d_wbd", k),   64'(o_wbd[k]),   64'(m_wbd[i]));
`else
    check($sformatf("d%0d_wbe", k),   64'(o_wbe[k]),   64'(0));
    check($sformatf("d%0d_wba", k),   64'(o_wba[k]),   64'(0));
    check($sformatf("d%0d_wbd", k),   64'(o_wbd[k]),   64'(0));
`endif
  endtask

  task automatic check_quiet(input string tag, input int k, input logic [31:0] exp_cnt);
    check({tag, $sformatf("_d%0d_valid", k)}, 64'(o_valid[k]), 64'(0));
    check({tag, $sformatf("_d%0d_busy", k)},  64'(o_busy[k]),  64'(0));
    check({tag, $sformatf("_d%0d_done", k)},  64'(o_done[k]),  64'(0));
    check({tag, $sformatf("_d%0d_last", k)},  64'(o_last[k]),  64'(0));
    check({tag, $sformatf("_d%0d_pc", k)},    64'(o_pc[k]),    64'(0));
    check({tag, $sformatf("_d%0d_count", k)}, 64'(o_cnt[k]),   64'(exp_cnt));
  endtask

  // mode 0: random, 1: wrap with trigger at n=15 of 20, 2: trigger on first commit.
  task automatic scenario(input int mode);
    logic [31:0] base, tp;
    int f[2], l[2];
    bit dn[2];
    int abort_at, cyc;
    bit rr;
    case (mode)
      1:       begin n_com = 20; base = 32'h0; t_idx = 15; end
      2:       begin n_com = 1; base = $urandom & 32'hFFFF_FF00; t_idx = 0; end
      default: begin
        n_com = $urandom_range(1, 20);
        base  = $urandom & 32'hFFFF_FF00;
        t_idx = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, n_com - 1);
      end
    endcase
    for (int i = 0; i < n_com; i++) begin
      m_pc[i]  = base + 32'(4 * i);
      m_ins[i] = $urandom;
      m_wbe[i] = 1'($urandom_range(0, 1));
      m_wba[i] = 5'($urandom_range(0, 31));
      m_wbd[i] = $urandom;
    end
    if (mode == 1) begin
      m_wbe[0] = 1'b1; m_wba[0] = 5'd5; m_wbd[0] = 32'hDEAD_BEEF;
    end
    tp = (t_idx >= 0) ? m_pc[t_idx] : base - 32'd4;

    // Arm; a matching commit on the arming edge must not be recorded.
    trig_pc = tp; arm = 1'b1; cap_valid = 1'b1; cap_pc = tp; cap_instr = $urandom;
    @(negedge clk);
    arm = 1'b0; cap_valid = 1'b0;

    for (int i = 0; i < n_com; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        if (t_idx < 0) rd_start = 1'($urandom_range(0, 1));
        @(negedge clk);
        rd_start = 1'b0;
      end
      cap_valid = 1'b1; cap_pc = m_pc[i]; cap_instr = m_ins[i];
      cap_wb_en = m_wbe[i]; cap_wb_addr = m_wba[i]; cap_wb_data = m_wbd[i];
      @(negedge clk);
      cap_valid = 1'b0;
    end

    for (int k = 0; k < 2; k++) begin
      model(k, f[k], l[k], dn[k]);
      check($sformatf("cap_d%0d_done", k),  64'(o_done[k]), 64'(dn[k]));
      check($sformatf("cap_d%0d_busy", k),  64'(o_busy[k]), 64'(1));
      check($sformatf("cap_d%0d_count", k), 64'(o_cnt[k]),  64'(l[k] - f[k] + 1));
    end

    if (!dn[1]) begin
      // Abort an unfinished capture; reset acts immediately.
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) check_quiet("rst_cap", k, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) check_quiet("idle_rdstart", k, 32'd0);
      return;
    end

    if (mode == 0 && $urandom_range(0, 4) == 0) return;  // next arm comes from DONE

    for (int i = f[0]; i <= l[0]; i++) q0.push_back(i);
    for (int i = f[1]; i <= l[1]; i++) q1.push_back(i);
    abort_at = (mode == 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : -1;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0) && cyc < 300) begin
      if (cyc == abort_at) begin
        rst = 1'b1; rd_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check_quiet("rst_rd", k, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_quiet("after_rst_rd", k, 32'd0);
        q0.delete(); q1.delete();
        return;
      end
      rr = ($urandom_range(0, 2) != 0);
      rd_ready = rr;
      if (q0.size() > 0) begin
        check_entry(0, q0[0], q0.size() == 1);
        if (rr) void'(q0.pop_front());
      end else begin
        check("rd_d0_idle_valid", 64'(o_valid[0]), 64'(0));
      end
      if (q1.size() > 0) begin
        check_entry(1, q1[0], q1.size() == 1);
        if (rr) void'(q1.pop_front());
      end else begin
        check("rd_d1_idle_valid", 64'(o_valid[1]), 64'(0));
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    check("rd_timeout_left", 64'(q0.size() + q1.size()), 64'(0));
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) check_quiet("rd_end", k, 32'(l[k] - f[k] + 1));
  endtask

  initial begin
    dep[0] = 4; pst[0] = 0;
    dep[1] = 8; pst[1] = 3;
    rst = 1'b1; cap_valid = 1'b0; cap_wb_en = 1'b0; arm = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    cap_pc = '0; cap_instr = '0; cap_wb_data = '0; trig_pc = '0; cap_wb_addr = '0;
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) check_quiet("reset", k, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    scenario(1);
    scenario(2);
    for (int s = 0; s < 40; s++) scenario(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
